// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge port between the MEM stage (master) and memory (slave).
interface mem_access_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: req/ack load/store, LED registers, switch sampling, MEM/WB bundle.
// Optional build macro MEMSTAGE_SWSYNC_EN puts a two-flop synchronizer on the switch input.
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [4:0]          phasecounter,
  input  logic                in_MemtoReg,
  input  logic                in_RegWrite,
  input  logic                in_MemRead,
  input  logic                in_MemWrite,
  input  logic [1:0]          in_ledout,
  input  logic                in_switchin,
  input  logic [15:0]         in_address,
  input  logic [15:0]         in_data,
  input  logic [2:0]          in_des,
  input  logic [15:0]         switch,
  mem_access_stage_if.master  mem,
  output logic [15:0]         led0,
  output logic [15:0]         led1,
  output logic                stall,
  output logic                mem_err,
  output logic                out_RegWrite,
  output logic [2:0]          out_des,
  output logic [15:0]         out_wbdata
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state;
  logic [15:0] tmo_cnt;
  logic [15:0] switch_val;

  // Instruction fields captured at the latch edge
  logic        lat_memtoreg;
  logic        lat_regwrite;
  logic        lat_switchin;
  logic        lat_read;
  logic [2:0]  lat_des;
  logic [15:0] lat_address;
  logic [15:0] lat_switch;

  logic        latch_en;
  logic        unused_phase;

  assign latch_en     = (state == IDLE) && phasecounter[3];
  assign stall        = (state == ACCESS);
  assign unused_phase = ^{phasecounter[4], phasecounter[2:0]};

  function automatic logic [15:0] wb_select(
    input logic        use_switch,
    input logic        use_mem,
    input logic [15:0] sw_value,
    input logic [15:0] rdata,
    input logic [15:0] address
  );
    if (use_switch)   return sw_value;
    else if (use_mem) return rdata;
    else              return address;
  endfunction

`ifdef MEMSTAGE_SWSYNC_EN
  logic [15:0] sw_sync_p0;
  logic [15:0] sw_sync_p1;

  // Synchronizer stages p0 -> p1
  always_ff @(posedge clock) begin
    if (reset) begin
      sw_sync_p0 <= '0;
      sw_sync_p1 <= '0;
    end else begin
      sw_sync_p0 <= switch;
      sw_sync_p1 <= sw_sync_p0;
    end
  end

  assign switch_val = sw_sync_p1;
`else
  assign switch_val = switch;
`endif

  // Latch stage: data fields only, qualified by the control FSM
  always_ff @(posedge clock) begin
    if (latch_en) begin
      lat_memtoreg <= in_MemtoReg;
      lat_regwrite <= in_RegWrite;
      lat_switchin <= in_switchin;
      lat_read     <= in_MemRead & ~in_MemWrite;
      lat_des      <= in_des;
      lat_address  <= in_address;
      lat_switch   <= switch_val;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      tmo_cnt      <= '0;
      mem.mem_req  <= 1'b0;
      mem.mem_we   <= 1'b0;
      mem.mem_addr <= '0;
      mem.mem_wdata <= '0;
      led0         <= '0;
      led1         <= '0;
      mem_err      <= 1'b0;
      out_RegWrite <= 1'b0;
      out_des      <= '0;
      out_wbdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (phasecounter[3]) begin
            tmo_cnt <= '0;
            if (in_ledout[0]) led0 <= in_data;
            if (in_ledout[1]) led1 <= in_data;
            if (in_MemWrite || in_MemRead) begin
              state        <= ACCESS;
              mem.mem_req  <= 1'b1;
              mem.mem_we   <= in_MemWrite;
              mem.mem_addr <= in_address;
              if (in_MemWrite) mem.mem_wdata <= in_data;
            end else begin
              out_RegWrite <= in_RegWrite;
              out_des      <= in_des;
              out_wbdata   <= wb_select(in_switchin, 1'b0, switch_val,
                                        mem.mem_rdata, in_address);
            end
          end
        end
        ACCESS: begin
          // An ack on the final allowed cycle still completes the access
          if (mem.mem_ack) begin
            state        <= IDLE;
            mem.mem_req  <= 1'b0;
            mem.mem_we   <= 1'b0;
            out_RegWrite <= lat_regwrite;
            out_des      <= lat_des;
            out_wbdata   <= wb_select(lat_switchin, lat_memtoreg & lat_read,
                                      lat_switch, mem.mem_rdata, lat_address);
          end else if (tmo_cnt == TMO_LAST) begin
            state        <= IDLE;
            mem.mem_req  <= 1'b0;
            mem.mem_we   <= 1'b0;
            mem_err      <= 1'b1;
            out_RegWrite <= 1'b0;
            out_des      <= '0;
            out_wbdata   <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: scoreboarded MEM/WB results plus bus/LED/timeout/reset checks.
module tb_mem_access_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  phasecounter;
  logic        in_MemtoReg, in_RegWrite, in_MemRead, in_MemWrite;
  logic [1:0]  in_ledout;
  logic        in_switchin;
  logic [15:0] in_address, in_data;
  logic [2:0]  in_des;
  logic [15:0] switch;
  logic [15:0] led0, led1;
  logic        stall, mem_err, out_RegWrite;
  logic [2:0]  out_des;
  logic [15:0] out_wbdata;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        rw;
    logic [2:0]  des;
    logic [15:0] wb;
  } exp_t;

  exp_t sb[$];

  mem_access_stage_if mif();

  mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .phasecounter (phasecounter),
    .in_MemtoReg  (in_MemtoReg),
    .in_RegWrite  (in_RegWrite),
    .in_MemRead   (in_MemRead),
    .in_MemWrite  (in_MemWrite),
    .in_ledout    (in_ledout),
    .in_switchin  (in_switchin),
    .in_address   (in_address),
    .in_data      (in_data),
    .in_des       (in_des),
    .switch       (switch),
    .mem          (mif),
    .led0         (led0),
    .led1         (led1),
    .stall        (stall),
    .mem_err      (mem_err),
    .out_RegWrite (out_RegWrite),
    .out_des      (out_des),
    .out_wbdata   (out_wbdata)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, " mem_req"},      16'(mif.mem_req),   16'h0);
    chk({tag, " mem_we"},       16'(mif.mem_we),    16'h0);
    chk({tag, " stall"},        16'(stall),         16'h0);
    chk({tag, " mem_err"},      16'(mem_err),       16'h0);
    chk({tag, " out_RegWrite"}, 16'(out_RegWrite),  16'h0);
    chk({tag, " mem_addr"},     mif.mem_addr,       16'h0);
    chk({tag, " mem_wdata"},    mif.mem_wdata,      16'h0);
    chk({tag, " led0"},         led0,               16'h0);
    chk({tag, " led1"},         led1,               16'h0);
    chk({tag, " out_des"},      16'(out_des),       16'h0);
    chk({tag, " out_wbdata"},   out_wbdata,         16'h0);
  endtask

  // ack_at: req cycle (1-based) on which mem_ack is returned; 0 = never
  task automatic run_op(input string tag, input logic rd, input logic wr,
                        input logic m2r, input logic rw, input logic swi,
                        input logic [1:0] led, input logic [15:0] addr,
                        input logic [15:0] data, input logic [2:0] des,
                        input int ack_at, input logic [15:0] rdata,
                        input int exp_stall);
    exp_t e;
    exp_t got;
    int   n;
    if ((rd || wr) && ack_at == 0) begin
      e = '0;
    end else begin
      e.rw  = rw;
      e.des = des;
      e.wb  = swi ? switch : ((m2r && rd && !wr) ? rdata : addr);
    end
    sb.push_back(e);

    @(negedge clock);
    phasecounter = 5'b01000;
    in_MemRead = rd; in_MemWrite = wr; in_MemtoReg = m2r; in_RegWrite = rw;
    in_switchin = swi; in_ledout = led; in_address = addr; in_data = data;
    in_des = des;
    @(posedge clock);
    #1;
    // Scramble inputs after the latch edge; the stage must ignore them
    phasecounter = 5'b10000;
    in_MemRead = 1'b0; in_MemWrite = 1'b0; in_RegWrite = ~rw; in_ledout = 2'b00;
    in_address = ~addr; in_data = ~data; in_des = ~des; in_switchin = ~swi;

    n = 0;
    if (rd || wr) begin
      for (int c = 1; c <= 20; c++) begin
        @(negedge clock);
        if (!stall) break;
        n++;
        chk({tag, " mem_req"},  16'(mif.mem_req), 16'h1);
        chk({tag, " mem_addr"}, mif.mem_addr,     addr);
        chk({tag, " mem_we"},   16'(mif.mem_we),  16'(wr));
        if (wr) chk({tag, " mem_wdata"}, mif.mem_wdata, data);
        if (c == ack_at) begin
          mif.mem_ack = 1'b1;
          mif.mem_rdata = rdata;
          @(posedge clock);
          #1;
          mif.mem_ack = 1'b0;
          mif.mem_rdata = 16'hDEAD;
        end
      end
    end else begin
      @(negedge clock);
    end

    chk({tag, " stall_cycles"}, 16'(n), 16'(exp_stall));
    chk({tag, " stall_low"},    16'(stall), 16'h0);
    chk({tag, " req_low"},      16'(mif.mem_req), 16'h0);
    got = sb.pop_front();
    chk({tag, " out_RegWrite"}, 16'(out_RegWrite), 16'(got.rw));
    chk({tag, " out_des"},      16'(out_des),      16'(got.des));
    chk({tag, " out_wbdata"},   out_wbdata,        got.wb);
    phasecounter = 5'b00001;
  endtask

  initial begin
    reset = 1'b1;
    phasecounter = 5'b00001;
    {in_MemtoReg, in_RegWrite, in_MemRead, in_MemWrite, in_switchin} = '0;
    in_ledout = 2'b00; in_address = '0; in_data = '0; in_des = '0;
    switch = 16'h0000;
    mif.mem_ack = 1'b0;
    mif.mem_rdata = 16'h0000;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check_outputs_zero("reset");

    // ALU op: no memory, result next cycle, LEDs untouched
    run_op("alu", 0, 0, 0, 1, 0, 2'b00, 16'h1234, 16'h5555, 3'd5, 0, 16'h0, 0);
    chk("alu led0", led0, 16'h0000);

    // Load with ack on third req cycle
    run_op("load", 1, 0, 1, 1, 0, 2'b00, 16'h0040, 16'h0000, 3'd2, 3, 16'hBEEF, 3);

    // Store with LED write to both, immediate ack
    run_op("store", 0, 1, 0, 0, 0, 2'b11, 16'h0080, 16'h00FF, 3'd1, 1, 16'h1111, 1);
    chk("store led0", led0, 16'h00FF);
    chk("store led1", led1, 16'h00FF);

    // LED select 01 only
    run_op("led01", 0, 0, 0, 0, 0, 2'b01, 16'h0001, 16'h0A0A, 3'd0, 0, 16'h0, 0);
    chk("led01 led0", led0, 16'h0A0A);
    chk("led01 led1", led1, 16'h00FF);

    // Read and write both set: write only, write-back from address
    run_op("rdwr", 1, 1, 1, 1, 0, 2'b00, 16'h0222, 16'h3333, 3'd3, 2, 16'h7777, 2);

    // Switch source wins over memory data
    switch = 16'hA5A5;
    repeat (4) @(negedge clock);
    run_op("switch", 1, 0, 1, 1, 1, 2'b00, 16'h0010, 16'h0000, 3'd6, 1, 16'h4444, 1);

    // Ack in IDLE must be ignored
    @(negedge clock);
    mif.mem_ack = 1'b1;
    @(negedge clock);
    mif.mem_ack = 1'b0;
    chk("idle_ack stall", 16'(stall), 16'h0);
    chk("idle_ack wbdata", out_wbdata, 16'hA5A5);
    chk("pre_timeout mem_err", 16'(mem_err), 16'h0);

    // Timeout after 4 ACCESS cycles
    run_op("timeout", 1, 0, 1, 1, 0, 2'b00, 16'h0050, 16'h0000, 3'd7, 0, 16'h0, 4);
    chk("timeout mem_err", 16'(mem_err), 16'h1);

    // Sticky error survives a normal op
    run_op("after_tmo", 0, 0, 0, 1, 0, 2'b00, 16'h0099, 16'h0000, 3'd4, 0, 16'h0, 0);
    chk("sticky mem_err", 16'(mem_err), 16'h1);

    // Reset on the second ACCESS cycle, then a stray ack
    @(negedge clock);
    phasecounter = 5'b01000;
    in_MemRead = 1'b1; in_MemWrite = 1'b0; in_MemtoReg = 1'b1; in_RegWrite = 1'b1;
    in_switchin = 1'b0; in_ledout = 2'b00; in_address = 16'h0060; in_des = 3'd1;
    @(posedge clock);
    #1;
    phasecounter = 5'b00001;
    @(negedge clock);
    chk("rst_mid req_c1", 16'(mif.mem_req), 16'h1);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check_outputs_zero("rst_mid");
    mif.mem_ack = 1'b1;
    mif.mem_rdata = 16'hCAFE;
    @(posedge clock);
    #1;
    mif.mem_ack = 1'b0;
    @(negedge clock);
    chk("late_ack stall",  16'(stall),        16'h0);
    chk("late_ack req",    16'(mif.mem_req),  16'h0);
    chk("late_ack wbdata", out_wbdata,        16'h0000);
    chk("late_ack rw",     16'(out_RegWrite), 16'h0);
    chk("sb_empty",        16'(sb.size()),    16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
